mem_port_arbiter: RTL

Arbitrates the core's instruction-fetch port and data load/store port onto one shared memory port. Owns the memory-side request/grant/response handshake, latches the winning request, and returns grant and read-response pulses to the owning requester. Sits between the fetch unit / data_mem stage and the single-ported memory model. Includes a response watchdog so a lost read response cannot hang the core.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, with a read-response watchdog.
// Define MEM_PORT_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats instr.
module mem_port_arbiter #(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [31:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rd_data_i,
  output logic        timeout_o
);

  localparam logic [1:0] BE_WORD   = 2'b10;
  localparam logic       OWN_INSTR = 1'b0;
  localparam logic       OWN_DATA  = 1'b1;
  localparam logic [7:0] CNT_LAST  = 8'(RSP_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic [31:0] r_addr;
  logic [1:0]  r_byte_en;
  logic        r_wr;
  logic [31:0] r_wr_data;
  logic [7:0]  r_cnt;
  logic        r_timeout;
  logic        w_win_data;
  logic        w_latch;
  logic        w_gnt;
  logic        w_rsp;
  logic        w_to;
  logic [31:0] w_rdata;

`ifdef MEM_PORT_ARB_RR_EN
  logic r_last_owner;

  // On a tie the requester that did not win last time goes first.
  assign w_win_data = data_req_i && (!instr_req_i || (r_last_owner == OWN_INSTR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= OWN_DATA;
    end else if (w_gnt) begin
      r_last_owner <= r_owner;
    end
  end
`else
  assign w_win_data = data_req_i;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_gnt   = 1'b0;
    w_rsp   = 1'b0;
    w_to    = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_req_i || data_req_i) begin
          w_latch = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          w_gnt  = 1'b1;
          w_next = r_wr ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response arriving on the last allowed cycle still counts as real data.
        w_to = !mem_rvalid_i && (r_cnt == CNT_LAST);
        if (mem_rvalid_i || w_to) begin
          w_rsp  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner   <= OWN_INSTR;
      r_addr    <= '0;
      r_byte_en <= '0;
      r_wr      <= 1'b0;
      r_wr_data <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_latch) begin
        r_owner <= w_win_data;
        if (w_win_data) begin
          r_addr    <= data_addr_i;
          r_byte_en <= data_byte_en_i;
          r_wr      <= data_wr_i;
          r_wr_data <= data_wr_data_i;
        end else begin
          r_addr    <= instr_addr_i;
          r_byte_en <= BE_WORD;
          r_wr      <= 1'b0;
          r_wr_data <= '0;
        end
      end
      if (w_gnt) begin
        r_cnt <= '0;
      end else if (r_state == WAIT_RSP) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_to) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_rdata = (w_rsp && mem_rvalid_i) ? mem_rd_data_i : '0;

  assign mem_req_o      = (r_state == ISSUE);
  assign mem_addr_o     = r_addr;
  assign mem_byte_en_o  = r_byte_en;
  assign mem_wr_o       = r_wr;
  assign mem_wr_data_o  = r_wr_data;
  assign timeout_o      = r_timeout;

  assign instr_gnt_o    = w_gnt && (r_owner == OWN_INSTR);
  assign instr_rvalid_o = w_rsp && (r_owner == OWN_INSTR);
  assign instr_rdata_o  = (r_owner == OWN_INSTR) ? w_rdata : '0;
  assign data_gnt_o     = w_gnt && (r_owner == OWN_DATA);
  assign data_rvalid_o  = w_rsp && (r_owner == OWN_DATA);
  assign data_rdata_o   = (r_owner == OWN_DATA) ? w_rdata : '0;

endmodule
